// File: rtl/clock_divider_bank_if.sv
// Configuration, readback and strobe bundle for the clock-enable bank.
// Latency: none, this is wiring only.
// Backpressure: none; the bank accepts every write and always drives its outputs.
interface clock_divider_bank_if #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2,
  parameter int DIV_W   = 20
);
  logic               clock_valid;
  logic               wr_en;
  logic [CH_BITS-1:0] wr_ch;
  logic [DIV_W-1:0]   wr_div;
  logic               wr_run;
  logic               sync_all;
  logic [CH_BITS-1:0] rd_ch;
  logic [DIV_W-1:0]   rd_div;
  logic               rd_run;
  logic [NUM_CH-1:0]  tick;
  logic [NUM_CH-1:0]  square;

  // Controller side: configures channels and consumes strobes.
  modport master (
    output clock_valid, wr_en, wr_ch, wr_div, wr_run, sync_all, rd_ch,
    input  rd_div, rd_run, tick, square
  );

  // Divider bank side.
  modport slave (
    input  clock_valid, wr_en, wr_ch, wr_div, wr_run, sync_all, rd_ch,
    output rd_div, rd_run, tick, square
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH programmable clock-enable generators (tick strobe + 50% square).
// Latency: tick/square registered; divisor readback one cycle after rd_ch.
// Backpressure: none; writes always accepted, clock_valid low freezes every phase.
module clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CH_BITS     = 2,
  parameter int DIV_W       = 20,
  parameter int DEFAULT_DIV = 3072
) (
  input  logic                clock,
  input  logic                reset,
  clock_divider_bank_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  count_q [NUM_CH];
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] square_q;
  logic [DIV_W-1:0]  rd_div_q;
  logic              rd_run_q;

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] wrap;
  logic [DIV_W-1:0]  rd_div_nxt;
  logic              rd_run_nxt;

  // Per-channel decode: write target, run condition and terminal count.
  // Channel selects beyond NUM_CH never match, so such writes fall away.
  always_comb begin
    wr_hit = '0;
    active = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = bus.wr_en && (bus.wr_ch == CH_BITS'(i));
      active[i] = run_q[i] && (div_q[i] != '0) && bus.clock_valid;
      wrap[i]   = (count_q[i] == div_q[i] - DIV_W'(1));
    end
  end

  // Readback mux; out-of-range channel selects read as zero.
  always_comb begin
    rd_div_nxt = '0;
    rd_run_nxt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CH_BITS'(i)) begin
        rd_div_nxt = div_q[i];
        rd_run_nxt = run_q[i];
      end
    end
  end

  // Channel state: reset, then sync/write restart, then normal counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_RST;
        count_q[i] <= '0;
      end
      run_q    <= '0;
      tick_q   <= '0;
      square_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sync_all || wr_hit[i]) begin
          // Restart the phase; a sync also forces square low, a lone write keeps it.
          count_q[i] <= '0;
          tick_q[i]  <= 1'b0;
          if (bus.sync_all) begin
            square_q[i] <= 1'b0;
          end
          if (wr_hit[i]) begin
            div_q[i] <= bus.wr_div;
            run_q[i] <= bus.wr_run;
          end
        end else if (active[i]) begin
          if (wrap[i]) begin
            count_q[i]  <= '0;
            tick_q[i]   <= 1'b1;
            square_q[i] <= ~square_q[i];
          end else begin
            count_q[i] <= count_q[i] + DIV_W'(1);
            tick_q[i]  <= 1'b0;
          end
        end else begin
          // Stopped or frozen: hold phase and square, suppress the strobe.
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  // Registered readback of the state left by the previous edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_div_q <= DIV_RST;
      rd_run_q <= 1'b0;
    end else begin
      rd_div_q <= rd_div_nxt;
      rd_run_q <= rd_run_nxt;
    end
  end

  assign bus.tick   = tick_q;
  assign bus.square = square_q;
  assign bus.rd_div = rd_div_q;
  assign bus.rd_run = rd_run_q;

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised bank of NUM_CH programmable clock-enable generators, all running from one fast clock (typically clock_25m or osc_50).
- Each channel produces a one-cycle strobe (tick) and a 50%-duty square output at a runtime-programmable rate.
- Replaces fixed counter-bit taps and hard-coded terminal counts; the 8.1 kHz audio rate becomes one programmed channel.
- Adds per-channel run control, global phase resync, clock_valid gating and divisor readback.

Parameters:
- NUM_CH, 4, number of channels (1..2**CH_BITS)
- CH_BITS, 2, width of channel-select fields
- DIV_W, 20, divisor and counter width
- DEFAULT_DIV, 3072, divisor loaded into every channel at reset

Ports:
- clock  input  1  single clock for all logic
- reset  input  1  synchronous, active-high
- clock_valid  input  1  1 = source clock stable; 0 freezes all channels
- wr_en  input  1  write strobe for channel configuration
- wr_ch  input  CH_BITS  channel written
- wr_div  input  DIV_W  new divisor D
- wr_run  input  1  new run bit
- sync_all  input  1  restart all channel phases
- rd_ch  input  CH_BITS  channel read back
- rd_div  output  DIV_W  registered divisor of rd_ch
- rd_run  output  1  registered run bit of rd_ch
- tick  output  NUM_CH  per-channel one-cycle strobe, registered
- square  output  NUM_CH  per-channel square wave, registered

Behaviour:
- Clocking and reset: all state updates on posedge clock only. Reset is synchronous and active-high.
- State at reset:
  - div[i] = DEFAULT_DIV, run[i] = 0, count[i] = 0
  - tick = 0, square = 0, rd_div = DEFAULT_DIV, rd_run = 0
- Channel i is active in a cycle when run[i] = 1, div[i] != 0 and clock_valid = 1.
- Active channel, per edge:
  - If count == div-1: count <= 0, tick[i] <= 1, square[i] <= ~square[i].
  - Otherwise: count <= count+1, tick[i] <= 0.
- Resulting timing:
  - tick period = D cycles; square period = 2D cycles, high for D, low for D.
  - First tick comes D active edges after the edge that set count to 0.
  - D = 1: tick constantly 1, square toggles every cycle.
- Inactive channel:
  - tick[i] <= 0; count and square hold.
  - clock_valid low freezes phase; it resumes exactly on return.
  - div = 0 is legal and means stopped.
- Write (wr_en = 1, wr_ch < NUM_CH):
  - div[wr_ch] <= wr_div, run[wr_ch] <= wr_run, count <= 0, tick <= 0; square holds.
  - The new divisor governs from the next edge.
  - Writes with wr_ch >= NUM_CH are ignored.
  - Writes are accepted even while clock_valid = 0.
- sync_all = 1: every count <= 0, square <= 0, tick <= 0; div and run unchanged.
  - With a simultaneous write, the write also applies div/run to its channel; count/tick zeroed, square <= 0 (sync wins on square).
- Priority: reset > sync_all/write > normal counting.
- Readback:
  - rd_div/rd_run <= div[rd_ch]/run[rd_ch], one-cycle latency.
  - Reflects state after the previous edge, so a write at edge t is visible on rd_* after edge t+1.
  - rd_ch >= NUM_CH returns 0/0.
- Counter arithmetic is DIV_W bits and never reaches div; D = 2**DIV_W-1 is the maximum.
- Reset mid-operation: all channels return to the reset state on that edge; no tick is issued on the reset edge.

Test Plan:
- Reset, then write ch0 D=4 run=1 at edge 0 -> tick[0] high after edges 4, 8, 12 (one cycle each); square[0] toggles at those edges (1, 0, 1); other channels stay 0.
- ch1 D=1 run=1 -> tick[1] constant 1, square[1] toggles every cycle; write ch1 D=3 mid-stream -> tick drops next edge, then reappears every 3rd edge with square held across the reload.
- ch2 D=5 running; drop clock_valid for 7 cycles at count 2 -> tick/square frozen, tick 0; on return the next tick comes 3 edges later.
- Channels 0-3 with D=2, 3, 5, 7 running; pulse sync_all -> all square=0, first ticks at +2, +3, +5, +7 edges; simultaneous write ch3 D=9 with sync_all -> ch3 first tick at +9.
- Write D=0 run=1 to ch0 -> no ticks for 100 cycles; write wr_ch=5 when NUM_CH=4 -> no state change; rd_ch=0 -> rd_div=0, rd_run=1 one cycle later; rd_ch=5 -> 0/0.
- Assert reset while all channels run -> next edge all outputs 0, rd_div=3072, and all run bits 0 (verified via readback).
